// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU, one-cycle logic/shift/add ops and
// iterative XLEN-cycle multiply, divide and remainder behind valid/ready.
module multicycle_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [1:0]      btype,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_bcond
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            bcond_q;
  logic [SHW-1:0]  cnt_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] mag_q;
  logic [XLEN-1:0] a_q;
  logic            neg_q;
  logic            rneg_q;
  logic            div0_q;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] sc_res;
  logic            sc_bcond;
  logic            iter_op;
  logic            sgn_op;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  // single-cycle result, branch compare and iterative operand setup
  always_comb begin
    sh       = alu_in_2[SHW-1:0];
    sc_res   = '0;
    sc_bcond = 1'b0;
    unique case (alu_op)
      5'd0:  sc_res = alu_in_1 + alu_in_2;
      5'd1:  sc_res = alu_in_1 - alu_in_2;
      5'd2:  sc_res = alu_in_1;
      5'd3:  sc_res = ~alu_in_1;
      5'd4:  sc_res = alu_in_1 & alu_in_2;
      5'd5:  sc_res = alu_in_1 | alu_in_2;
      5'd6:  sc_res = ~(alu_in_1 & alu_in_2);
      5'd7:  sc_res = ~(alu_in_1 | alu_in_2);
      5'd8:  sc_res = alu_in_1 ^ alu_in_2;
      5'd9:  sc_res = ~(alu_in_1 ^ alu_in_2);
      5'd10: sc_res = alu_in_1 << sh;
      5'd11: sc_res = alu_in_1 >> sh;
      5'd12: sc_res = alu_in_1 << sh;
      5'd13: sc_res = $signed(alu_in_1) >>> sh;
      5'd14: sc_res = -alu_in_1;
      default: sc_res = '0;
    endcase
    if (alu_op == 5'd1) begin
      unique case (btype)
        2'b00: sc_bcond = (alu_in_1 == alu_in_2);
        2'b01: sc_bcond = (alu_in_1 != alu_in_2);
        2'b10: sc_bcond = ($signed(alu_in_1) < $signed(alu_in_2));
        default: sc_bcond = !($signed(alu_in_1) < $signed(alu_in_2));
      endcase
    end
    iter_op = (alu_op >= 5'd16) && (alu_op <= 5'd21);
    sgn_op  = (alu_op != 5'd19) && (alu_op != 5'd21);
    sa      = sgn_op & alu_in_1[XLEN-1];
    sb      = sgn_op & alu_in_2[XLEN-1];
    mag_a   = sa ? -alu_in_1 : alu_in_1;
    mag_b   = sb ? -alu_in_2 : alu_in_2;
  end

  logic            is_mul;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_try;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [XLEN-1:0] it_hi;
  logic [XLEN-1:0] it_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fin_res;

  // one shift-add or restoring-divide step, plus final sign fix-up
  always_comb begin
    is_mul  = (op_q == 5'd16) || (op_q == 5'd17);
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    rem_try = {hi_q, lo_q[XLEN-1]};
    ge      = rem_try >= {1'b0, mag_q};
    diff    = rem_try[XLEN-1:0] - mag_q;
    if (is_mul) begin
      it_hi = sum[XLEN:1];
      it_lo = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      it_hi = ge ? diff : rem_try[XLEN-1:0];
      it_lo = {lo_q[XLEN-2:0], ge};
    end
    prod = {it_hi, it_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -it_lo : it_lo;
    rem = rneg_q ? -it_hi : it_hi;
    if (div0_q) begin
      quo = '1;
      rem = a_q;
    end
    unique case (op_q)
      5'd16: fin_res = prod[XLEN-1:0];
      5'd17: fin_res = prod[2*XLEN-1:XLEN];
      5'd18, 5'd19: fin_res = quo;
      default: fin_res = rem;
    endcase
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      bcond_q     <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mag_q       <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            if (iter_op) begin
              state_q    <= S_CALC;
              in_ready_q <= 1'b0;
              op_q       <= alu_op;
              cnt_q      <= '0;
              hi_q       <= '0;
              a_q        <= alu_in_1;
              neg_q      <= sa ^ sb;
              rneg_q     <= sa;
              div0_q     <= (alu_op >= 5'd18) && (alu_in_2 == '0);
              if (alu_op <= 5'd17) begin
                lo_q  <= mag_b;
                mag_q <= mag_a;
              end else begin
                lo_q  <= mag_a;
                mag_q <= mag_b;
              end
            end else begin
              result_q    <= sc_res;
              bcond_q     <= sc_bcond;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_CALC: begin
          hi_q  <= it_hi;
          lo_q  <= it_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN - 1)) begin
            state_q     <= S_DONE;
            result_q    <= fin_res;
            bcond_q     <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with a queue scoreboard and a
// monitor that checks result, bcond and latency on every out_valid pulse.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_op = '0;
  logic [1:0]  btype = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        alu_bcond;

  logic        v16 = 1'b0;
  logic        rdy16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ov16;
  logic [15:0] r16;
  logic        bc16;

  multicycle_alu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .btype(btype), .alu_in_1(a), .alu_in_2(b),
    .out_valid(out_valid), .alu_result(alu_result), .alu_bcond(alu_bcond)
  );

  multicycle_alu #(.XLEN(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
    .alu_op(5'd16), .btype(2'b00), .alu_in_1(a16), .alu_in_2(b16),
    .out_valid(ov16), .alu_result(r16), .alu_bcond(bc16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_acc;
  int   last_wait;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", alu_result, e.res);
        check("bcond", {31'd0, alu_bcond}, {31'd0, e.bc});
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [1:0] bt,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic eb);
    exp_t e;
    int w;
    @(negedge clk);
    alu_op = op; btype = bt; a = x; b = y; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("accept_timeout", 32'd1, 32'd0);
    last_wait = w;
    last_acc = cyc;
    e.res = er; e.bc = eb;
    e.lat = (op >= 5'd16 && op <= 5'd21) ? 33 : 1;
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic busy_len(input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    check(nm, w, 33);
  endtask

  initial begin
    int t0;
    int n;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_bcond", {31'd0, alu_bcond}, 32'd0);
    reset = 1'b0;

    // reset in the middle of a divide
    issue(5'd18, 2'b00, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", alu_result, 32'd0);
    repeat (40) @(negedge clk);
    issue(5'd0, 2'b00, 32'd5, 32'd7, 32'd12, 1'b0);

    // back-to-back single-cycle ops
    issue(5'd1, 2'b00, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    issue(5'd13, 2'b00, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
    issue(5'd14, 2'b00, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    issue(5'd10, 2'b00, 32'h1, 32'h21, 32'h2, 1'b0);
    issue(5'd9, 2'b00, 32'hF0F0_0000, 32'h0FF0_0000, 32'h00FF_FFFF, 1'b0);
    issue(5'd25, 2'b00, 32'h1234, 32'h5678, 32'd0, 1'b0);

    // branch compares
    issue(5'd1, 2'b10, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    issue(5'd1, 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(5'd1, 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(5'd1, 2'b00, 32'd9, 32'd9, 32'd0, 1'b1);
    issue(5'd1, 2'b01, 32'd9, 32'd9, 32'd0, 1'b0);
    issue(5'd0, 2'b00, 32'd9, 32'd9, 32'd18, 1'b0);

    // multiply
    issue(5'd16, 2'b00, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0);
    busy_len("mul_busy");
    issue(5'd17, 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    busy_len("mulh_busy");
    issue(5'd17, 2'b00, 32'h4000_0000, 32'd4, 32'h0000_0001, 1'b0);
    busy_len("mulh2_busy");

    // divide and remainder
    issue(5'd18, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    busy_len("div_busy");
    issue(5'd20, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    busy_len("rem_busy");
    issue(5'd19, 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);
    busy_len("divu0_busy");
    issue(5'd21, 2'b00, 32'd7, 32'd0, 32'd7, 1'b0);
    busy_len("remu0_busy");
    issue(5'd18, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    busy_len("divov_busy");
    issue(5'd20, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    busy_len("remov_busy");
    issue(5'd18, 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    busy_len("div0_busy");
    issue(5'd21, 2'b00, 32'd100, 32'd7, 32'd2, 1'b0);
    busy_len("remu_busy");

    // request held while busy is taken in the first idle cycle
    issue(5'd16, 2'b00, 32'd6, 32'd7, 32'd42, 1'b0);
    t0 = last_acc;
    issue(5'd0, 2'b00, 32'd1, 32'd2, 32'd3, 1'b0);
    check("held_wait", last_wait, 33);
    check("held_accept", last_acc - t0, 34);

    // XLEN = 16 instance
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov16 && n < 100);
    check("x16_latency", n, 17);
    check("x16_result", {16'd0, r16}, 32'h0001);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised successor to the single-cycle datapath ALU. Executes the existing logic, shift and add/sub operations in one registered cycle and adds iterative RV32M-style multiply, divide and remainder over XLEN cycles. Operations are accepted through a valid/ready handshake; results come back as a one-cycle output pulse. The block sits in the execute stage of the multi-cycle CPU; the control FSM stalls on `in_ready`.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width; derived, not overridden.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `alu_op`  in  5  operation code (below).
- `btype`  in  2  branch compare: 00 EQ, 01 NE, 10 LT (signed), 11 GE (signed).
- `alu_in_1`  in  XLEN  operand A.
- `alu_in_2`  in  XLEN  operand B.
- `out_valid`  out  1  result valid; one-cycle pulse.
- `alu_result`  out  XLEN  registered result; holds until next out_valid.
- `alu_bcond`  out  1  registered branch condition; qualified by out_valid.

## Operation
- Accept = `in_valid && in_ready`. Operands, op and btype are latched on accept; inputs are ignored at all other times.
- Single-cycle ops: 0 ADD, 1 SUB, 2 PASS A, 3 NOT A, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, 10 SLL, 11 SRL, 12 SLA (= SLL), 13 SRA, 14 NEG A (two's complement), 15 ZERO.
- Iterative ops: 16 MUL (low XLEN of product), 17 MULH (high XLEN, signed×signed), 18 DIV (signed), 19 DIVU, 20 REM (signed), 21 REMU. Codes 22–31 are single-cycle and return 0.
- Shifts use `alu_in_2[SHW-1:0]` only. SRA replicates A's MSB.
- All add/sub/neg arithmetic wraps modulo 2^XLEN; no flags.
- `alu_bcond`: computed only for SUB; 0 for every other op. EQ: A==B. NE: A!=B. LT: $signed(A)<$signed(B). GE: the negation of LT. Signed compare must be correct on overflow; sign-of-difference is not acceptable.
- MUL/MULH: radix-2 shift-add over magnitudes, with sign fix-up on the 2·XLEN product.
- DIV/REM: restoring division over magnitudes. The quotient sign is sign(A)^sign(B); the remainder takes the sign of A.
- Divide by zero: quotient = all ones; remainder = A. This applies to signed and unsigned ops and takes no special latency.
- Signed overflow (A = most-negative, B = −1): quotient = A, remainder = 0.
- FSM states:
  - IDLE: in_ready=1. An accepted single-cycle op goes to IDLE again and registers its result. An accepted iterative op goes to CALC.
  - CALC: count from 0 to XLEN−1, one iteration per cycle. At count XLEN−1, go to DONE.
  - DONE: apply sign fix-up, register the result, pulse out_valid, go to IDLE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, alu_result 0, alu_bcond 0, counter 0.
- Reset asserted in any state aborts the operation within one edge. No out_valid is produced for the aborted op.
- Single-cycle op accepted in cycle T: out_valid=1 with result in cycle T+1.
  - in_ready stays 1, so back-to-back accepts give a result every cycle.
- Iterative op accepted in cycle T:
  - in_ready=0 in cycles T+1 … T+XLEN+1.
  - out_valid=1 in cycle T+XLEN+1.
  - in_ready=1 again in cycle T+XLEN+2. An accept in that cycle overlaps nothing.
- out_valid is high for exactly one cycle per accepted op. There is no backpressure; the consumer must capture on the pulse.
- in_valid while in_ready=0 is dropped. The requester must hold the request until accepted.

## Test plan
- Reset mid-DIV: after reset, in_ready=1, out_valid=0, result 0, and no pulse follows. Then ADD 5+7 returns 12 at T+1.
- Back-to-back single-cycle ops:
  - SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 0x24 → 0xF8000000 (shift 4).
  - NEG 1 → 0xFFFFFFFF.
  - Expect three consecutive out_valid cycles.
- Branch, SUB with BLT:
  - A=0x80000000, B=1 → bcond=1.
  - A=0x7FFFFFFF, B=0xFFFFFFFF: BGE → 1, BLT → 0.
  - BEQ 9,9 → 1.
- Multiply, each with out_valid exactly 33 cycles after accept and in_ready low for the 33 intervening cycles:
  - MUL 0xFFFFFFFF×3 → 0xFFFFFFFD.
  - MULH −2×3 → 0xFFFFFFFF.
  - MULH 0x40000000×4 → 0x00000001.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF.
  - REMU 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- Request while busy: in_valid held during CALC is ignored and accepted in the first IDLE cycle. Rerun with XLEN=16: MUL latency is 17, and MUL 0xFFFF×0xFFFF → 0x0001.
